// File: rtl/axi32_regbank.sv
// AXI4-Lite register slave with control outputs and synchronised status inputs.
// Also provides sticky W1C event capture, a level interrupt and SLVERR on unmapped indices.
module axi32_regbank #(
    parameter int unsigned       datawidth = 32,
    parameter int unsigned       addrwidth = 8,
    parameter int unsigned       ch_num    = 8,
    parameter logic [31:0]       version   = 32'h0001_0000,
    parameter logic [ch_num-1:0] ctrl_init = '0
) (
    input  logic                   s_axi_clk_in,
    input  logic                   s_axi_reset_in,
    input  logic [addrwidth-1:0]   s_axi_awaddr_in,
    input  logic                   s_axi_awvalid_in,
    output logic                   s_axi_awready_out,
    input  logic [datawidth-1:0]   s_axi_wdata_in,
    input  logic [datawidth/8-1:0] s_axi_wstrb_in,
    input  logic                   s_axi_wvalid_in,
    output logic                   s_axi_wready_out,
    output logic [1:0]             s_axi_bresp_out,
    output logic                   s_axi_bvalid_out,
    input  logic                   s_axi_bready_in,
    input  logic [addrwidth-1:0]   s_axi_araddr_in,
    input  logic                   s_axi_arvalid_in,
    output logic                   s_axi_arready_out,
    output logic [datawidth-1:0]   s_axi_rdata_out,
    output logic [1:0]             s_axi_rresp_out,
    output logic                   s_axi_rvalid_out,
    input  logic                   s_axi_rready_in,
    output logic [ch_num-1:0]      control_out,
    input  logic [ch_num-1:0]      status_in,
    output logic                   irq_out
);
    localparam int NB  = datawidth / 8;
    localparam int LSB = $clog2(NB);
    localparam int IW  = addrwidth - LSB;

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rstate_t;

    wstate_t               wstate_q;
    rstate_t               rstate_q;
    logic                  awready_q, wready_q, bvalid_q;
    logic [1:0]            bresp_q;
    logic                  arready_q, rvalid_q;
    logic [1:0]            rresp_q, rresp_d;
    logic [datawidth-1:0]  rdata_q, rdata_d;
    logic [ch_num-1:0]     ctrl_q, ctrl_d, irqen_q, irqen_d, sticky_q, sticky_d;
    logic [datawidth-1:0]  scratch_q, scratch_d;
    logic [ch_num-1:0]     sync1_q, sync2_q, sync3_q;
    logic                  irq_q;

    logic [IW-1:0]         widx, ridx;
    logic [datawidth-1:0]  wmask;
    logic [ch_num-1:0]     rise, clr;
    logic                  wen, wmapped;
    logic                  unused_addr_bits;

    assign widx    = s_axi_awaddr_in[addrwidth-1:LSB];
    assign ridx    = s_axi_araddr_in[addrwidth-1:LSB];
    assign wen     = (wstate_q == W_ACK);
    assign wmapped = (widx < IW'(6));
    assign rise    = sync2_q & ~sync3_q;
    assign unused_addr_bits = ^{s_axi_awaddr_in[LSB-1:0], s_axi_araddr_in[LSB-1:0]};

    function automatic logic [datawidth-1:0] merge_bytes(input logic [datawidth-1:0] old_v,
                                                         input logic [datawidth-1:0] new_v,
                                                         input logic [datawidth-1:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    always_comb begin
        wmask = '0;
        for (int b = 0; b < NB; b++) begin
            wmask[b*8 +: 8] = {8{s_axi_wstrb_in[b]}};
        end
    end

    // A new status edge overrides a coincident W1C so no event is ever lost.
    always_comb begin
        ctrl_d    = ctrl_q;
        irqen_d   = irqen_q;
        scratch_d = scratch_q;
        clr       = '0;
        if (wen) begin
            case (widx)
                IW'(1):  ctrl_d    = ch_num'(merge_bytes(datawidth'(ctrl_q), s_axi_wdata_in, wmask));
                IW'(3):  clr       = ch_num'(s_axi_wdata_in & wmask);
                IW'(4):  irqen_d   = ch_num'(merge_bytes(datawidth'(irqen_q), s_axi_wdata_in, wmask));
                IW'(5):  scratch_d = merge_bytes(scratch_q, s_axi_wdata_in, wmask);
                default: ;
            endcase
        end
        sticky_d = (sticky_q & ~clr) | rise;
    end

    always_comb begin
        rdata_d = '0;
        rresp_d = 2'b00;
        case (ridx)
            IW'(0):  rdata_d = datawidth'(version);
            IW'(1):  rdata_d = datawidth'(ctrl_q);
            IW'(2):  rdata_d = datawidth'(sync2_q);
            IW'(3):  rdata_d = datawidth'(sticky_q);
            IW'(4):  rdata_d = datawidth'(irqen_q);
            IW'(5):  rdata_d = scratch_q;
            default: rresp_d = 2'b10;
        endcase
    end

    always_ff @(posedge s_axi_clk_in or posedge s_axi_reset_in) begin
        if (s_axi_reset_in) begin
            ctrl_q    <= ctrl_init;
            irqen_q   <= '0;
            sticky_q  <= '0;
            scratch_q <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            sync3_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            irqen_q   <= irqen_d;
            sticky_q  <= sticky_d;
            scratch_q <= scratch_d;
            sync1_q   <= status_in;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            irq_q     <= |(sticky_q & irqen_q);
        end
    end

    always_ff @(posedge s_axi_clk_in or posedge s_axi_reset_in) begin
        if (s_axi_reset_in) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            case (wstate_q)
                W_IDLE: if (s_axi_awvalid_in && s_axi_wvalid_in) begin
                    awready_q <= 1'b1;
                    wready_q  <= 1'b1;
                    wstate_q  <= W_ACK;
                end
                W_ACK: begin
                    awready_q <= 1'b0;
                    wready_q  <= 1'b0;
                    bvalid_q  <= 1'b1;
                    bresp_q   <= wmapped ? 2'b00 : 2'b10;
                    wstate_q  <= W_RESP;
                end
                W_RESP: if (s_axi_bready_in) begin
                    bvalid_q <= 1'b0;
                    bresp_q  <= 2'b00;
                    wstate_q <= W_IDLE;
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge s_axi_clk_in or posedge s_axi_reset_in) begin
        if (s_axi_reset_in) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: if (s_axi_arvalid_in) begin
                    arready_q <= 1'b1;
                    rstate_q  <= R_ACK;
                end
                R_ACK: begin
                    arready_q <= 1'b0;
                    rvalid_q  <= 1'b1;
                    rdata_q   <= rdata_d;
                    rresp_q   <= rresp_d;
                    rstate_q  <= R_DATA;
                end
                R_DATA: if (s_axi_rready_in) begin
                    rvalid_q <= 1'b0;
                    rstate_q <= R_IDLE;
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign s_axi_awready_out = awready_q;
    assign s_axi_wready_out  = wready_q;
    assign s_axi_bvalid_out  = bvalid_q;
    assign s_axi_bresp_out   = bresp_q;
    assign s_axi_arready_out = arready_q;
    assign s_axi_rvalid_out  = rvalid_q;
    assign s_axi_rresp_out   = rresp_q;
    assign s_axi_rdata_out   = rdata_q;
    assign control_out       = ctrl_q;
    assign irq_out           = irq_q;
endmodule

// File: tb/tb_axi32_regbank.sv
// Bench for axi32_regbank: directed and random AXI-Lite traffic, responses scoreboarded
// against a byte-level register model held in the bench.
module tb_axi32_regbank;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  awAddr = '0, arAddr = '0;
    logic        awValid = 1'b0, wValid = 1'b0, bReady = 1'b0, arValid = 1'b0, rReady = 1'b0;
    logic [31:0] wData = '0;
    logic [3:0]  wStrb = '0;
    logic [7:0]  status = '0;
    logic        awReady, wReady, bValid, arReady, rValid, irq;
    logic [1:0]  bResp, rResp;
    logic [31:0] rData;
    logic [7:0]  control;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;

    logic [1:0]  bq[$];
    logic [33:0] rq[$];
    logic [1:0]  expB;
    logic [33:0] expR;

    logic [7:0]  mCtrl = 8'hA5, mIrqEn = '0, mSticky = '0, mStatus = '0;
    logic [31:0] mScratch = '0;

    axi32_regbank #(
        .datawidth(32), .addrwidth(8), .ch_num(8),
        .version(32'h0001_0000), .ctrl_init(8'hA5)
    ) dut (
        .s_axi_clk_in(clk),          .s_axi_reset_in(rst),
        .s_axi_awaddr_in(awAddr),    .s_axi_awvalid_in(awValid), .s_axi_awready_out(awReady),
        .s_axi_wdata_in(wData),      .s_axi_wstrb_in(wStrb),
        .s_axi_wvalid_in(wValid),    .s_axi_wready_out(wReady),
        .s_axi_bresp_out(bResp),     .s_axi_bvalid_out(bValid),  .s_axi_bready_in(bReady),
        .s_axi_araddr_in(arAddr),    .s_axi_arvalid_in(arValid), .s_axi_arready_out(arReady),
        .s_axi_rdata_out(rData),     .s_axi_rresp_out(rResp),
        .s_axi_rvalid_out(rValid),   .s_axi_rready_in(rReady),
        .control_out(control),       .status_in(status),         .irq_out(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        nChecks++;
        if (act !== expv) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic reportTimeout(input string name);
        nChecks++;
        nFails++;
        $display("[TB] FAIL %s: timed out waiting on DUT", name);
    endtask

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] data,
                                               input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = data[b*8 +: 8];
        return r;
    endfunction

    function automatic void modelWrite(input logic [7:0] addr, input logic [31:0] data,
                                       input logic [3:0] strb, output logic [1:0] resp);
        logic [31:0] t;
        resp = 2'b00;
        case (int'(addr) / 4)
            0, 2: ;
            1: begin t = mergeBytes({24'd0, mCtrl}, data, strb);  mCtrl  = t[7:0]; end
            3: begin t = mergeBytes(32'd0, data, strb);           mSticky = mSticky & ~t[7:0]; end
            4: begin t = mergeBytes({24'd0, mIrqEn}, data, strb); mIrqEn = t[7:0]; end
            5: mScratch = mergeBytes(mScratch, data, strb);
            default: resp = 2'b10;
        endcase
    endfunction

    function automatic logic [33:0] modelRead(input logic [7:0] addr);
        case (int'(addr) / 4)
            0: return {2'b00, 32'h0001_0000};
            1: return {2'b00, 24'd0, mCtrl};
            2: return {2'b00, 24'd0, mStatus};
            3: return {2'b00, 24'd0, mSticky};
            4: return {2'b00, 24'd0, mIrqEn};
            5: return {2'b00, mScratch};
            default: return {2'b10, 32'd0};
        endcase
    endfunction

    // Scoreboard: every completed handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bValid && bReady) begin
            if (bq.size() == 0) begin
                nChecks++; nFails++;
                $display("[TB] FAIL unexpected_bresp: got %b, expected no response", bResp);
            end else begin
                expB = bq.pop_front();
                checkOutput("bresp", 32'(bResp), 32'(expB));
            end
        end
        if (!rst && rValid && rReady) begin
            if (rq.size() == 0) begin
                nChecks++; nFails++;
                $display("[TB] FAIL unexpected_rdata: got %h, expected no response", rData);
            end else begin
                expR = rq.pop_front();
                checkOutput("rdata", rData, expR[31:0]);
                checkOutput("rresp", 32'(rResp), 32'(expR[33:32]));
            end
        end
    end

    task automatic axiWrite(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int awLead, input int bHold, output int ackLat, output int respLat);
        logic [1:0] e;
        int wCyc;
        modelWrite(addr, data, strb, e);
        bq.push_back(e);
        @(posedge clk); #1;
        awAddr = addr; awValid = 1'b1; wData = data; wStrb = strb;
        bReady = (bHold == 0);
        ackLat = -1; respLat = -1;
        for (int i = 0; i < awLead; i++) begin
            @(negedge clk);
            checkOutput("awready_before_wvalid", 32'(awReady), 32'd0);
            @(posedge clk); #1;
        end
        wValid = 1'b1;
        wCyc = cyc;
        for (int i = 0; i < 20 && ackLat < 0; i++) begin
            @(negedge clk);
            if (awReady && wReady) ackLat = cyc - wCyc;
        end
        @(posedge clk); #1;
        awValid = 1'b0; wValid = 1'b0;
        if (ackLat < 0) begin
            reportTimeout("aw_w_handshake");
            bReady = 1'b0;
            return;
        end
        for (int i = 0; i < 20 && respLat < 0; i++) begin
            @(negedge clk);
            if (bValid) respLat = cyc - wCyc;
        end
        if (respLat < 0) begin
            reportTimeout("bvalid");
            bReady = 1'b0;
            return;
        end
        if (bHold > 0) begin
            for (int i = 0; i < bHold; i++) begin
                @(negedge clk);
                checkOutput("bvalid_held", 32'(bValid), 32'd1);
            end
            @(posedge clk); #1;
            bReady = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        bReady = 1'b0;
        @(negedge clk);
        checkOutput("bvalid_dropped", 32'(bValid), 32'd0);
    endtask

    task automatic axiRead(input logic [7:0] addr, input int rHold, output int ackLat, output int dataLat);
        int aCyc;
        rq.push_back(modelRead(addr));
        @(posedge clk); #1;
        arAddr = addr; arValid = 1'b1; rReady = (rHold == 0);
        aCyc = cyc;
        ackLat = -1; dataLat = -1;
        for (int i = 0; i < 20 && ackLat < 0; i++) begin
            @(negedge clk);
            if (arReady) ackLat = cyc - aCyc;
        end
        @(posedge clk); #1;
        arValid = 1'b0;
        if (ackLat < 0) begin
            reportTimeout("ar_handshake");
            rReady = 1'b0;
            return;
        end
        for (int i = 0; i < 20 && dataLat < 0; i++) begin
            @(negedge clk);
            if (rValid) dataLat = cyc - aCyc;
        end
        if (dataLat < 0) begin
            reportTimeout("rvalid");
            rReady = 1'b0;
            return;
        end
        if (rHold > 0) begin
            for (int i = 0; i < rHold; i++) begin
                @(negedge clk);
                checkOutput("rvalid_held", 32'(rValid), 32'd1);
            end
            @(posedge clk); #1;
            rReady = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        rReady = 1'b0;
        @(negedge clk);
        checkOutput("rvalid_dropped", 32'(rValid), 32'd0);
    endtask

    task automatic waitIrq(input logic expv, input string name);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (irq == expv) break;
        end
        checkOutput(name, 32'(irq), 32'(expv));
    endtask

    task automatic applyStimulus(input int nOps);
        int a, l;
        logic [7:0] addr;
        for (int n = 0; n < nOps; n++) begin
            addr = 8'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                axiWrite(addr, $urandom, 4'($urandom), 0, $urandom_range(0, 2), a, l);
            else
                axiRead(addr, $urandom_range(0, 2), a, l);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a, l, a2, l2;
        bit seen, bad;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_handshake_outs", {27'd0, awReady, wReady, bValid, arReady, rValid}, 32'd0);
        checkOutput("reset_irq", 32'(irq), 32'd0);
        checkOutput("reset_resp", {28'd0, bResp, rResp}, 32'd0);
        checkOutput("reset_rdata", rData, 32'd0);
        checkOutput("reset_control", 32'(control), 32'h0000_00A5);
        rst = 1'b0;

        axiRead(8'h00, 0, a, l);
        checkOutput("read_arready_latency", 32'(a), 32'd1);
        checkOutput("read_rvalid_latency", 32'(l), 32'd2);

        axiWrite(8'h14, 32'hDEADBEEF, 4'b0101, 0, 3, a, l);
        checkOutput("write_ack_latency", 32'(a), 32'd1);
        checkOutput("write_bvalid_latency", 32'(l), 32'd2);
        axiRead(8'h16, 1, a, l);

        axiWrite(8'h04, 32'h0000_003C, 4'hF, 0, 0, a, l);
        checkOutput("control_out", 32'(control), 32'(mCtrl));
        axiWrite(8'h05, 32'hFFFF_FF00, 4'b1110, 0, 0, a, l);
        checkOutput("control_strobe_off", 32'(control), 32'(mCtrl));

        status = 8'h08;
        repeat (6) @(posedge clk);
        #1;
        mStatus = 8'h08;
        mSticky = mSticky | 8'h08;
        axiRead(8'h0C, 0, a, l);
        axiRead(8'h08, 0, a, l);
        checkOutput("irq_while_disabled", 32'(irq), 32'd0);
        axiWrite(8'h10, 32'h0000_0008, 4'hF, 0, 0, a, l);
        waitIrq(1'b1, "irq_raise");
        axiWrite(8'h0C, 32'h0000_0008, 4'hF, 0, 0, a, l);
        waitIrq(1'b0, "irq_clear");
        axiRead(8'h0C, 0, a, l);

        status = 8'h00;
        repeat (5) @(posedge clk);
        mStatus = 8'h00;
        @(posedge clk); #1;
        status = 8'h08;
        axiWrite(8'h0C, 32'h0000_0008, 4'hF, 0, 0, a, l);
        mStatus = 8'h08;
        mSticky = mSticky | 8'h08;
        axiRead(8'h0C, 0, a, l);
        waitIrq(1'b1, "irq_set_beats_clear");
        axiWrite(8'h0C, 32'h0000_00FF, 4'b0001, 0, 0, a, l);
        axiRead(8'h0C, 0, a, l);
        status = 8'h00;
        repeat (5) @(posedge clk);
        mStatus = 8'h00;

        axiWrite(8'h1C, 32'hFFFF_FFFF, 4'hF, 0, 0, a, l);
        axiRead(8'h1C, 0, a, l);
        axiRead(8'h3D, 0, a, l);
        axiWrite(8'h00, 32'h1234_5678, 4'hF, 0, 0, a, l);
        axiWrite(8'h08, 32'hFFFF_FFFF, 4'hF, 0, 0, a, l);
        axiRead(8'h00, 0, a, l);
        axiRead(8'h14, 0, a, l);
        axiRead(8'h04, 0, a, l);

        axiWrite(8'h14, 32'h1234_5678, 4'hF, 5, 0, a, l);
        checkOutput("awready_after_wvalid", 32'(a), 32'd1);

        fork
            axiWrite(8'h14, 32'hCAFE_F00D, 4'hF, 0, 1, a, l);
            begin
                axiRead(8'h04, 0, a2, l2);
                axiRead(8'h00, 1, a2, l2);
            end
        join
        checkOutput("concurrent_write_latency", 32'(l), 32'd2);
        axiRead(8'h14, 0, a, l);

        applyStimulus(40);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("irq_final", 32'(irq), 32'(|(mSticky & mIrqEn)));
        checkOutput("control_final", 32'(control), 32'(mCtrl));

        @(posedge clk); #1;
        awAddr = 8'h04; wData = 32'h0000_0011; wStrb = 4'hF;
        awValid = 1'b1; wValid = 1'b1; bReady = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bValid) seen = 1'b1;
        end
        checkOutput("bvalid_before_reset", 32'(seen), 32'd1);
        checkOutput("control_before_reset", 32'(control), 32'h0000_0011);
        awValid = 1'b0; wValid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("bvalid_in_reset", 32'(bValid), 32'd0);
        checkOutput("control_in_reset", 32'(control), 32'h0000_00A5);
        @(posedge clk); #1;
        rst = 1'b0;
        bReady = 1'b1;
        mCtrl = 8'hA5; mIrqEn = '0; mSticky = '0; mScratch = '0;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bValid) bad = 1'b1;
        end
        checkOutput("no_bvalid_after_reset", 32'(bad), 32'd0);
        bReady = 1'b0;
        axiRead(8'h04, 0, a, l);
        axiRead(8'h14, 0, a, l);
        checkOutput("queues_drained", 32'(bq.size() + rq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
